// File: rtl/ads1256_avg_filter.sv
// Boxcar averager for ADS1256 samples: 1/4/16/64-sample windows, floor divide.
// ADS1256_AVG_MINMAX_EN adds per-window signed min/max outputs.
module ads1256_avg_filter #(
  parameter logic [1:0] AVG_SEL_RST = 2'd2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [23:0] ad_value,
  input  logic        ad_done,
  input  logic [1:0]  avg_sel,
  input  logic        cfg_ld,
  input  logic        clear,
  output logic [23:0] avg_value,
  output logic        avg_valid,
  output logic        ovr_flag,
`ifdef ADS1256_AVG_MINMAX_EN
  output logic [23:0] min_value,
  output logic [23:0] max_value,
`endif
  output logic [6:0]  fill_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_EMIT
  } state_t;

  state_t state_q, state_d;

  logic sync1_q, sync2_q, edge_q;
  logic strobe;

  logic [1:0] win_sel_q;
  logic [1:0] n_sel_q, n_sel_d;
  logic [6:0] n_len;
  logic       win_start;

  logic signed [29:0] acc_q;
  logic signed [29:0] base_acc;
  logic signed [29:0] sample_ext;
  logic signed [29:0] shifted;
  logic [6:0]  base_fill, fill_inc;
  logic        ovr_q, base_ovr, full_scale;

`ifdef ADS1256_AVG_MINMAX_EN
  logic [23:0] min_q, max_q;
  logic [23:0] min_d, max_d;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= ad_done;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign strobe = sync2_q & ~edge_q;

  assign sample_ext = {{6{ad_value[23]}}, ad_value};
  assign full_scale = (ad_value == 24'h7FFFFF) |
                      (ad_value == 24'h800000);
  // Shift uses the length latched for the window being emitted.
  assign shifted = acc_q >>> {n_sel_q, 1'b0};

  always_comb begin
    win_start = 1'b1;
    state_d   = S_ACC;
    unique case (state_q)
      S_IDLE:  win_start = 1'b1;
      S_ACC:   win_start = 1'b0;
      S_EMIT:  win_start = 1'b1;
      default: win_start = 1'b1;
    endcase
    n_sel_d   = win_start ? win_sel_q : n_sel_q;
    n_len     = 7'd1 << {n_sel_d, 1'b0};
    base_fill = win_start ? 7'd0 : fill_cnt;
    base_acc  = win_start ? 30'sd0 : acc_q;
    base_ovr  = win_start ? 1'b0 : ovr_q;
    fill_inc  = base_fill + 7'd1;
    if (clear)
      state_d = S_IDLE;
    else if (strobe && fill_inc == n_len)
      state_d = S_EMIT;
  end

`ifdef ADS1256_AVG_MINMAX_EN
  always_comb begin
    min_d = ad_value;
    max_d = ad_value;
    if (base_fill != 7'd0) begin
      if (!($signed(ad_value) < $signed(min_q)))
        min_d = min_q;
      if (!($signed(ad_value) > $signed(max_q)))
        max_d = max_q;
    end
  end
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)
      win_sel_q <= AVG_SEL_RST;
    else if (cfg_ld)
      win_sel_q <= avg_sel;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      n_sel_q  <= AVG_SEL_RST;
      acc_q    <= '0;
      fill_cnt <= '0;
      ovr_q    <= 1'b0;
`ifdef ADS1256_AVG_MINMAX_EN
      min_q    <= '0;
      max_q    <= '0;
`endif
    end else if (clear) begin
      acc_q    <= '0;
      fill_cnt <= '0;
      ovr_q    <= 1'b0;
    end else begin
      n_sel_q <= n_sel_d;
      if (strobe) begin
        acc_q    <= base_acc + sample_ext;
        fill_cnt <= fill_inc;
        ovr_q    <= base_ovr | full_scale;
`ifdef ADS1256_AVG_MINMAX_EN
        min_q    <= min_d;
        max_q    <= max_d;
`endif
      end else if (win_start) begin
        acc_q    <= '0;
        fill_cnt <= '0;
        ovr_q    <= 1'b0;
      end
    end
  end

  // A clear that lands on the emit cycle discards the window.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_value <= '0;
      avg_valid <= 1'b0;
      ovr_flag  <= 1'b0;
`ifdef ADS1256_AVG_MINMAX_EN
      min_value <= '0;
      max_value <= '0;
`endif
    end else begin
      avg_valid <= 1'b0;
      if (state_q == S_EMIT && !clear) begin
        avg_value <= shifted[23:0];
        avg_valid <= 1'b1;
        ovr_flag  <= ovr_q;
`ifdef ADS1256_AVG_MINMAX_EN
        min_value <= min_q;
        max_value <= max_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ads1256_avg_filter.sv
// Directed bench for ads1256_avg_filter with an expected-result queue.
// Expected averages are computed by hand from the sample values.
module tb_ads1256_avg_filter;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic [23:0] ad_value;
  logic        ad_done;
  logic [1:0]  avg_sel;
  logic        cfg_ld;
  logic        clear;
  logic [23:0] avg_value;
  logic        avg_valid;
  logic        ovr_flag;
  logic [6:0]  fill_cnt;
`ifdef ADS1256_AVG_MINMAX_EN
  logic [23:0] min_value, max_value;
`endif

  typedef struct {
    logic [23:0] avg;
    logic        ovr;
    logic [23:0] mn;
    logic [23:0] mx;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int n_valid = 0;
  int n_push = 0;

  always #5 sys_clk = ~sys_clk;

  ads1256_avg_filter dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .ad_value (ad_value),
    .ad_done  (ad_done),
    .avg_sel  (avg_sel),
    .cfg_ld   (cfg_ld),
    .clear    (clear),
    .avg_value(avg_value),
    .avg_valid(avg_valid),
    .ovr_flag (ovr_flag),
`ifdef ADS1256_AVG_MINMAX_EN
    .min_value(min_value),
    .max_value(max_value),
`endif
    .fill_cnt (fill_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [23:0] a, input logic o,
                      input logic [23:0] mn, input logic [23:0] mx);
    exp_t e;
    e.avg = a;
    e.ovr = o;
    e.mn  = mn;
    e.mx  = mx;
    q.push_back(e);
    n_push++;
  endtask

  task automatic sample(input logic [23:0] v);
    @(negedge sys_clk);
    ad_value = v;
    ad_done  = 1'b1;
    repeat (4) @(negedge sys_clk);
    ad_done = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic pulse_clear;
    @(negedge sys_clk);
    clear = 1'b1;
    @(negedge sys_clk);
    clear = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] s);
    @(negedge sys_clk);
    avg_sel = s;
    cfg_ld  = 1'b1;
    @(negedge sys_clk);
    cfg_ld = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    if (rst_n === 1'b1 && avg_valid === 1'b1) begin
      exp_t e;
      n_valid++;
      chk("sb_nonempty", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("avg_value", {8'd0, avg_value}, {8'd0, e.avg});
        chk("ovr_flag", {31'd0, ovr_flag}, {31'd0, e.ovr});
`ifdef ADS1256_AVG_MINMAX_EN
        chk("min_value", {8'd0, min_value}, {8'd0, e.mn});
        chk("max_value", {8'd0, max_value}, {8'd0, e.mx});
`endif
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ad_value = '0;
    ad_done  = 1'b0;
    avg_sel  = 2'd0;
    cfg_ld   = 1'b0;
    clear    = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_avg_value", {8'd0, avg_value}, 32'd0);
    chk("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
    chk("rst_ovr_flag", {31'd0, ovr_flag}, 32'd0);
    chk("rst_fill_cnt", {25'd0, fill_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // N=4 basic average, floor of 1001/4
    cfg(2'd1);
    pulse_clear();
    push(24'd250, 1'b0, 24'd100, 24'd401);
    sample(24'd100);
    sample(24'd200);
    sample(24'd300);
    sample(24'd401);
    repeat (4) @(negedge sys_clk);
    chk("fill_after_emit", {25'd0, fill_cnt}, 32'd0);

    // negative floor: -5/4 -> -2
    push(24'hFFFFFE, 1'b0, 24'hFFFFFE, 24'hFFFFFF);
    sample(24'hFFFFFF);
    sample(24'hFFFFFF);
    sample(24'hFFFFFF);
    sample(24'hFFFFFE);

    // N=64 full scale
    cfg(2'd3);
    pulse_clear();
    push(24'h7FFFFF, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
    for (int i = 0; i < 64; i++) sample(24'h7FFFFF);

    // N=16 partial window, clear, then full window
    cfg(2'd2);
    pulse_clear();
    for (int i = 0; i < 7; i++) sample(24'd10);
    chk("fill_partial", {25'd0, fill_cnt}, 32'd7);
    pulse_clear();
    @(negedge sys_clk);
    chk("fill_after_clear", {25'd0, fill_cnt}, 32'd0);
    push(24'd10, 1'b0, 24'd10, 24'd10);
    for (int i = 0; i < 16; i++) sample(24'd10);

    // mid-window cfg_ld does not truncate; N=1 afterwards
    cfg(2'd1);
    pulse_clear();
    push(24'd10, 1'b0, 24'd4, 24'd16);
    sample(24'd4);
    sample(24'd8);
    cfg(2'd0);
    sample(24'd12);
    chk("fill_no_trunc", {25'd0, fill_cnt}, 32'd3);
    sample(24'd16);
    push(24'hFFFFF9, 1'b0, 24'hFFFFF9, 24'hFFFFF9);
    sample(24'hFFFFF9);
    push(24'h7FFFFF, 1'b1, 24'h7FFFFF, 24'h7FFFFF);
    sample(24'h7FFFFF);
    repeat (4) @(negedge sys_clk);

    // reset mid-window discards partial data
    cfg(2'd1);
    pulse_clear();
    sample(24'd99);
    sample(24'd99);
    sample(24'd99);
    @(negedge sys_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst2_fill_cnt", {25'd0, fill_cnt}, 32'd0);
    chk("rst2_avg_value", {8'd0, avg_value}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    cfg(2'd1);
    pulse_clear();
    push(24'd5, 1'b0, 24'd5, 24'd5);
    for (int i = 0; i < 4; i++) sample(24'd5);
    repeat (4) @(negedge sys_clk);

    // ad_done high at reset release yields one strobe
    ad_value = 24'd3;
    ad_done  = 1'b1;
    rst_n    = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    chk("strobe_at_release", {25'd0, fill_cnt}, 32'd1);
    ad_done = 1'b0;
    repeat (4) @(negedge sys_clk);

    chk("sb_empty", q.size(), 32'd0);
    chk("valid_count", n_valid, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
